// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - single-access load/store initiator for the peripheral bus
module bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_rd,
  output logic        o_wr,
  output logic [31:0] o_addr,
  output logic [3:0]  o_wrmask,
  output logic [31:0] o_data,
  input  logic        i_rd_valid,
  input  logic        i_wr_valid,
  input  logic [31:0] i_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wrmask_q, wrmask_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          misaligned;
  logic          match_valid;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  always_comb begin
    misaligned = (i_req_size == 2'd3) ||
                 ((i_req_size == 2'd1) && i_req_addr[0]) ||
                 ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));
    match_valid = we_q ? i_wr_valid : i_rd_valid;
    shifted     = i_data >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = i_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    off_d    = off_q;
    size_d   = size_q;
    uns_d    = uns_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wrmask_d = wrmask_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          off_d   = i_req_addr[1:0];
          size_d  = i_req_size;
          uns_d   = i_req_unsigned;
          rdata_d = 32'b0;
          cnt_d   = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUS;
            rd_d    = ~i_req_we;
            wr_d    = i_req_we;
            addr_d  = {i_req_addr[31:2], 2'b00};
            if (i_req_we) begin
              case (i_req_size)
                2'd0: begin
                  wrmask_d = 4'b0001 << i_req_addr[1:0];
                  data_d   = {4{i_req_wdata[7:0]}};
                end
                2'd1: begin
                  wrmask_d = i_req_addr[1] ? 4'b1100 : 4'b0011;
                  data_d   = {2{i_req_wdata[15:0]}};
                end
                default: begin
                  wrmask_d = 4'b1111;
                  data_d   = i_req_wdata;
                end
              endcase
            end else begin
              wrmask_d = 4'b0;
              data_d   = 32'b0;
            end
          end
        end
      end
      BUS: begin
        cnt_d = cnt_q + CW'(1);
        // A valid in the final wait cycle still completes the access cleanly.
        if (match_valid || (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
          state_d  = RESP;
          err_d    = ~match_valid;
          rdata_d  = (match_valid && !we_q) ? load_ext : 32'b0;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          addr_d   = 32'b0;
          wrmask_d = 4'b0;
          data_d   = 32'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      off_q    <= 2'b0;
      size_q   <= 2'b0;
      uns_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 32'b0;
      wrmask_q <= 4'b0;
      data_q   <= 32'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wrmask_q <= wrmask_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_resp_valid = (state_q == RESP);
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;
  assign o_rd         = rd_q;
  assign o_wr         = wr_q;
  assign o_addr       = addr_q;
  assign o_wrmask     = wrmask_q;
  assign o_data       = data_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - randomized and directed checks of bus_initiator against a reference model
module tb_bus_initiator;

  localparam int T      = 4;
  localparam int SILENT = 99;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_rd;
  logic        o_wr;
  logic [31:0] o_addr;
  logic [3:0]  o_wrmask;
  logic [31:0] o_data;
  logic        i_rd_valid;
  logic        i_wr_valid;
  logic [31:0] i_data;

  int n_cmp = 0;
  int n_bad = 0;

  bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_rd(o_rd), .o_wr(o_wr), .o_addr(o_addr), .o_wrmask(o_wrmask), .o_data(o_data),
    .i_rd_valid(i_rd_valid), .i_wr_valid(i_wr_valid), .i_data(i_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = word >> (8 * off);
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // lat = number of BUS cycles before the responder answers (>= T or SILENT means no answer in time)
  task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int lat,
                        input logic [31:0] rsrc, input logic stray);
    logic        mis;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
    int          n;
    int          bus_cycles;
    int          exp_cycles;
    mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    exp_mask = 4'b0;
    exp_data = 32'b0;
    if (we) begin
      if (size == 2'd0) begin
        exp_mask = 4'(1 << addr[1:0]);
        exp_data = (wdata % 256) * 32'h01010101;
      end else if (size == 2'd1) begin
        exp_mask = addr[1] ? 4'hC : 4'h3;
        exp_data = (wdata % 65536) * 32'h00010001;
      end else begin
        exp_mask = 4'hF;
        exp_data = wdata;
      end
    end

    check("ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_addr     = addr;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_wdata    = wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;

    if (mis) begin
      check("mis_resp_valid", 32'(o_resp_valid), 32'd1);
      check("mis_err", 32'(o_resp_err), 32'd1);
      check("mis_rdata", o_resp_rdata, 32'd0);
      check("mis_no_bus", 32'({o_rd, o_wr}), 32'd0);
      check("mis_ready_low", 32'(o_req_ready), 32'd0);
    end else begin
      n = 0;
      bus_cycles = 0;
      while (!o_resp_valid && n < T + 3) begin
        check("bus_rd", 32'(o_rd), 32'(!we));
        check("bus_wr", 32'(o_wr), 32'(we));
        check("bus_addr", o_addr, {addr[31:2], 2'b00});
        check("bus_mask", 32'(o_wrmask), 32'(exp_mask));
        check("bus_data", o_data, exp_data);
        check("bus_ready_low", 32'(o_req_ready), 32'd0);
        bus_cycles++;
        i_data = $urandom;
        if (stray) begin
          if (we) i_rd_valid = 1'b1;
          else    i_wr_valid = 1'b1;
        end
        if (n == lat) begin
          if (we) i_wr_valid = 1'b1;
          else begin
            i_rd_valid = 1'b1;
            i_data     = rsrc;
          end
        end
        @(negedge clk);
        i_rd_valid = 1'b0;
        i_wr_valid = 1'b0;
        n++;
      end
      exp_cycles = (lat < T) ? lat + 1 : T;
      exp_rdata  = (lat < T && !we) ? model_load(rsrc, addr[1:0], size, uns) : 32'd0;
      check("bus_cycles", 32'(bus_cycles), 32'(exp_cycles));
      check("resp_valid", 32'(o_resp_valid), 32'd1);
      check("resp_err", 32'(o_resp_err), 32'(lat >= T));
      check("resp_rdata", o_resp_rdata, exp_rdata);
      check("resp_bus_idle", 32'({o_rd, o_wr, o_wrmask}), 32'd0);
      check("resp_ready_low", 32'(o_req_ready), 32'd0);
    end
    @(negedge clk);
    check("resp_one_cycle", 32'(o_resp_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    i_req_valid    = 1'b0;
    i_req_we       = 1'b0;
    i_req_addr     = 32'b0;
    i_req_size     = 2'b0;
    i_req_unsigned = 1'b0;
    i_req_wdata    = 32'b0;
    i_rd_valid     = 1'b0;
    i_wr_valid     = 1'b0;
    i_data         = 32'b0;
    repeat (3) @(negedge clk);
    check("rst_bus", 32'({o_rd, o_wr, o_wrmask}), 32'd0);
    check("rst_addr", o_addr, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_resp", 32'({o_resp_valid, o_resp_err}), 32'd0);
    check("rst_rdata", o_resp_rdata, 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 32'h1000_0008, 2'd2, 1'b0, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    access(1'b1, 32'h1000_0003, 2'd0, 1'b0, 32'h0000_00A5, 1, 32'h0, 1'b0);
    access(1'b1, 32'h1000_0002, 2'd1, 1'b0, 32'h0000_1234, 2, 32'h0, 1'b0);
    access(1'b0, 32'h2000_0002, 2'd0, 1'b0, 32'h0, 0, 32'h80F0_7F01, 1'b0);
    access(1'b0, 32'h2000_0002, 2'd0, 1'b1, 32'h0, 0, 32'h80F0_7F01, 1'b0);
    access(1'b0, 32'h2000_0000, 2'd1, 1'b0, 32'h0, 0, 32'h80F0_7F01, 1'b0);
    access(1'b0, 32'h2000_0002, 2'd1, 1'b0, 32'h0, 0, 32'h80F0_7F01, 1'b0);
    access(1'b0, 32'h3000_0001, 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    access(1'b1, 32'h3000_0003, 2'd1, 1'b0, 32'h5555, 0, 32'h0, 1'b0);
    access(1'b0, 32'h3000_0000, 2'd3, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    access(1'b0, 32'h4000_0004, 2'd2, 1'b0, 32'h0, SILENT, 32'h0, 1'b0);
    access(1'b0, 32'h4000_0004, 2'd2, 1'b0, 32'h0, T - 1, 32'hCAFE_F00D, 1'b0);
    access(1'b0, 32'h4000_0004, 2'd2, 1'b0, 32'h0, SILENT, 32'h0, 1'b1);
    access(1'b1, 32'h4000_0000, 2'd2, 1'b0, 32'h1, SILENT, 32'h0, 1'b1);

    // Reset during a BUS wait: outputs clear at once and no response ever follows.
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h5000_0010;
    i_req_size  = 2'd2;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_rd", 32'(o_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd", 32'(o_rd), 32'd0);
    check("async_rst_addr", o_addr, 32'd0);
    check("async_rst_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < T + 3; k++) begin
      check("no_resp_after_rst", 32'({o_resp_valid, o_rd}), 32'd0);
      @(negedge clk);
    end
    access(1'b0, 32'h5000_0010, 2'd2, 1'b0, 32'h0, 1, 32'h1357_9BDF, 1'b0);

    for (int r = 0; r < 80; r++) begin
      logic [1:0] sz;
      int         lat;
      sz  = 2'($urandom_range(0, 3));
      lat = $urandom_range(0, T + 1);
      access(1'($urandom), $urandom, sz, 1'($urandom), $urandom, lat, $urandom,
             ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Load/store bus initiator for the SoC's peripheral bus. It accepts one byte, half or word access at a time from the core, drives the shared `rd/wr/addr/wrmask/data` request lines to the memory-mapped responders, and waits for the matching `rd_valid`/`wr_valid`. It then returns aligned, extended read data or a completion, with a misalignment/timeout error flag.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles in BUS waiting for a valid before the access is failed (≥1).
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_req_valid`  in  1  core request present
- `o_req_ready`  out  1  initiator can accept a request (high only in IDLE)
- `i_req_we`  in  1  1 = store, 0 = load
- `i_req_addr`  in  32  byte address
- `i_req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- `i_req_unsigned`  in  1  zero-extend loads (else sign-extend)
- `i_req_wdata`  in  32  store data, right-justified
- `o_resp_valid`  out  1  one-cycle completion pulse
- `o_resp_rdata`  out  32  extended load data (0 for stores/errors)
- `o_resp_err`  out  1  misaligned, illegal size or timeout; qualified by `o_resp_valid`
- `o_rd`, `o_wr`  out  1 each  bus read/write request, level, held until acknowledged
- `o_addr`  out  32  word-aligned bus address `{addr[31:2],2'b00}`
- `o_wrmask`  out  4  byte-lane write enables
- `o_data`  out  32  lane-replicated store data
- `i_rd_valid`, `i_wr_valid`  in  1 each  responder acknowledge
- `i_data`  in  32  responder read data, valid with `i_rd_valid`

## Operation
- The block has three states: IDLE, BUS and RESP. Reset state is IDLE.
- **IDLE:**
  - `o_req_ready=1`.
  - On `i_req_valid`, latch the request.
  - Misaligned requests go directly to RESP with err=1 and no bus activity. Misaligned means: half with `addr[0]=1`, word with `addr[1:0]≠0`, or size 3.
  - All other requests go to BUS with the timeout counter cleared.
- **Store lanes:**
  - Byte: `o_wrmask = 4'b0001<<addr[1:0]` and `o_data={4{wdata[7:0]}}`.
  - Half: `o_wrmask` is 0011 for `addr[1]=0` or 1100 for `addr[1]=1`, and `o_data={2{wdata[15:0]}}`.
  - Word: `o_wrmask` is 1111 and `o_data=wdata`.
- **BUS:**
  - Assert `o_rd` (load) or `o_wr` (store), with `o_addr`/`o_wrmask`/`o_data` stable for the whole state.
  - For a load, `o_wrmask=0` and `o_data=0`.
  - Only the matching valid counts: `i_rd_valid` for loads, `i_wr_valid` for stores. The non-matching valid is ignored.
  - When the matching valid is sampled high, capture `i_data` for a load and go to RESP with err=0.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, go to RESP with err=1 and rdata=0.
  - If valid and timeout occur in the same cycle, valid wins.
- **Load extraction:** shift `i_data` right by `8*addr[1:0]`, then take 8 or 16 bits and sign- or zero-extend per `i_req_unsigned`. A word load is passed through unchanged.
- **RESP:**
  - `o_resp_valid=1` for exactly one cycle, with rdata/err from registers.
  - Next state is IDLE.
  - There is no response backpressure.
- **Outside BUS:** `o_rd`, `o_wr`, `o_addr`, `o_wrmask` and `o_data` are all 0.

## Timing
- **Reset values:**
  - `o_rd`, `o_wr`, `o_addr`, `o_wrmask`, `o_data`, `o_resp_valid`, `o_resp_rdata` and `o_resp_err` are 0.
  - `o_req_ready=1` (state IDLE). Requests are not accepted while `rst_n=0`.
- **Accepted access (accepted at end of cycle 0):**
  - Cycle 1: bus request asserted.
  - A responder with a combinational valid in cycle 1 gives `o_resp_valid` in cycle 2.
  - `o_req_ready` returns in cycle 3.
  - Minimum 3 cycles per access. Each extra responder wait cycle adds 1.
- **Misaligned access:** `o_resp_valid` in cycle 1, no bus cycle, `o_req_ready` in cycle 2.
- **Timeout:** err response appears `TIMEOUT_CYCLES`+1 cycles after acceptance.
- **Bus outputs:** all bus outputs are registered; none depends combinationally on core inputs.
- **Reset mid-operation:**
  - All outputs drop to 0 asynchronously and the state returns to IDLE.
  - The in-flight access is abandoned and produces no response.
- The counter must not wrap. Size it to `$clog2(TIMEOUT_CYCLES+1)` bits.

## Test plan
- **Word store, zero-wait responder:** store word 0xDEADBEEF to 0x1000_0008.
  - Cycle 1: `o_wr=1`, `o_addr=0x10000008`, `o_wrmask=1111`, `o_data=0xDEADBEEF`.
  - Cycle 2: `o_resp_valid=1`, err=0.
  - Cycle 3: ready.
- **Byte/half stores:**
  - Byte 0xA5 to addr offset 3 → `wrmask=1000`, `o_data=0xA5A5A5A5`.
  - Half 0x1234 to offset 2 → `wrmask=1100`, `o_data=0x12341234`.
- **Loads with extension:**
  - Responder returns 0x80F0_7F01.
  - Signed byte at offset 2 → 0xFFFFFFF0.
  - Unsigned byte at offset 2 → 0x000000F0.
  - Signed half at offset 0 → 0x00007F01.
  - Signed half at offset 2 → 0xFFFF80F0.
- **Misaligned:**
  - Word at 0x...01, half at 0x...03, or size 3 → `o_resp_valid`+err in cycle 1.
  - `o_rd`/`o_wr` never assert.
- **Timeout and valid priority:** with `TIMEOUT_CYCLES=4`:
  - A silent responder gives err=1, rdata=0, and `o_rd` is held exactly 4 cycles.
  - Valid arriving in the 4th BUS cycle gives err=0.
  - A stray `i_wr_valid` during a load is ignored.
- **Reset mid-access:**
  - Assert `rst_n=0` during a BUS wait → outputs 0 immediately and no `o_resp_valid` after release.
  - A following request completes normally.
